// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag definitions for the multicycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_UDIV = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_SDIV = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1000;
  localparam logic [3:0] OP_LSL  = 4'b1001;
  localparam logic [3:0] OP_LSR  = 4'b1010;
  localparam logic [3:0] OP_ASR  = 4'b1011;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, restore on underflow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;
  logic           qbit;

  // One extra bit keeps the shifted remainder from overflowing.
  assign sh    = {rem_i, quo_i[WIDTH-1]};
  assign diff  = sh - {1'b0, dvs_i};
  assign qbit  = ~diff[WIDTH];
  assign rem_o = qbit ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], qbit};

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle logic/arith, shift-add multiply,
// restoring signed/unsigned divide, valid/ready on both sides.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic [3:0]       flags,
  output logic             div_by_zero
);

  localparam int MSB = WIDTH - 1;
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH:0]   ONE_W    = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {MSB{1'b0}}};

  state_e           state_q, state_d;
  logic             go_q, go_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [3:0]       flg_q, flg_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] s_res;
  logic             s_c, s_v;
  logic [SHW-1:0]   sh;
  logic             is_mul, is_div, is_sdiv;
  logic             a_neg, b_neg, ovf;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
  logic [WIDTH-1:0] mul_acc, st_rem, st_quo;

  function automatic logic [3:0] mk_flags(
    input logic [WIDTH-1:0] r,
    input logic             c,
    input logic             v
  );
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = r[MSB];
    f[FLAG_Z] = ~|r;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  // go_q marks the operand-capture cycle before work starts.
  assign in_ready  = reset & (state_q == S_IDLE) & ~go_q;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == S_DONE);
  assign result    = res_q;
  assign remainder = rem_q;
  assign flags     = flg_q;
  assign div_by_zero = dbz_q;

  assign sh      = b_q[SHW-1:0];
  assign is_mul  = (op_q == OP_MUL);
  assign is_sdiv = (op_q == OP_SDIV);
  assign is_div  = (op_q == OP_UDIV) | is_sdiv;
  assign a_neg   = is_sdiv & a_q[MSB];
  assign b_neg   = is_sdiv & b_q[MSB];
  assign a_mag   = a_neg ? -a_q : a_q;
  assign b_mag   = b_neg ? -b_q : b_q;
  assign q_fix   = (a_neg ^ b_neg) ? -quo_q : quo_q;
  assign r_fix   = a_neg ? -acc_q : acc_q;
  assign ovf     = is_sdiv & (a_q == MIN_NEG) & (&b_q);
  assign mul_acc = quo_q[0] ? acc_q + dvs_q : acc_q;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i (acc_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (st_rem),
    .quo_o (st_quo)
  );

  always_comb begin
    sum_w = '0;
    s_res = '0;
    s_c   = 1'b0;
    s_v   = 1'b0;
    case (op_q)
      OP_ADD: begin
        sum_w = {1'b0, a_q} + {1'b0, b_q};
        s_res = sum_w[MSB:0];
        s_c   = sum_w[WIDTH];
        s_v   = (a_q[MSB] == b_q[MSB]) & (s_res[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        sum_w = {1'b0, a_q} + {1'b0, ~b_q} + ONE_W;
        s_res = sum_w[MSB:0];
        s_c   = sum_w[WIDTH];
        s_v   = (a_q[MSB] != b_q[MSB]) & (s_res[MSB] != a_q[MSB]);
      end
      OP_AND: s_res = a_q & b_q;
      OP_OR:  s_res = a_q | b_q;
      OP_XOR: s_res = a_q ^ b_q;
      OP_NOT: s_res = ~a_q;
      OP_LSL: s_res = a_q << sh;
      OP_LSR: s_res = a_q >> sh;
      OP_ASR: s_res = $unsigned($signed(a_q) >>> sh);
      default: s_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    go_d    = go_q;
    acc_d   = acc_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    rem_d   = rem_q;
    flg_d   = flg_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (go_q) begin
          go_d  = 1'b0;
          cnt_d = CNT_INIT;
          acc_d = '0;
          if (is_mul) begin
            quo_d   = b_q;
            dvs_d   = a_q;
            state_d = S_MUL;
          end else if (is_div) begin
            quo_d   = a_mag;
            dvs_d   = b_mag;
            state_d = S_DIV;
          end else begin
            res_d   = s_res;
            rem_d   = '0;
            flg_d   = mk_flags(s_res, s_c, s_v);
            dbz_d   = 1'b0;
            state_d = S_DONE;
          end
        end else if (accept) begin
          go_d = 1'b1;
        end
      end
      S_MUL: begin
        acc_d = mul_acc;
        dvs_d = dvs_q << 1;
        quo_d = quo_q >> 1;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          res_d   = mul_acc;
          rem_d   = '0;
          flg_d   = mk_flags(mul_acc, 1'b0, 1'b0);
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        acc_d = st_rem;
        quo_d = st_quo;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        if (b_q == '0) begin
          res_d = '0;
          rem_d = a_q;
          flg_d = mk_flags('0, 1'b0, 1'b0);
          dbz_d = 1'b1;
        end else begin
          res_d = q_fix;
          rem_d = r_fix;
          flg_d = mk_flags(q_fix, 1'b0, ovf);
          dbz_d = 1'b0;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      go_q    <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      rem_q   <= '0;
      flg_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      go_q    <= go_d;
      acc_q   <= acc_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      flg_q   <= flg_d;
      dbz_q   <= dbz_d;
      if (accept) begin
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: driver pushes model results,
// monitor pops and compares on each out_valid.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result, remainder;
  logic [3:0]  flags;
  logic        div_by_zero;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] res;
    logic [31:0] rem;
    logic [3:0]  flg;
    logic        dbz;
    int          lat;
    int          acc;
    int          hold;
  } exp_t;

  exp_t sbq[$];

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .remainder   (remainder),
    .flags       (flags),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o,
                                 input logic [31:0] x,
                                 input logic [31:0] y);
    exp_t e;
    longint sx, sy, s, q, r;
    logic [63:0] u;
    logic c, v;
    e.res = '0; e.rem = '0; e.dbz = 1'b0;
    e.lat = 1; e.acc = 0; e.hold = 0;
    c = 1'b0; v = 1'b0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      4'd0: begin
        u = {32'd0, x} + {32'd0, y};
        e.res = u[31:0];
        c = u[32];
        s = sx + sy;
        v = (s > SMAX) || (s < SMIN);
      end
      4'd1: begin
        e.res = x - y;
        c = (x >= y);
        s = sx - sy;
        v = (s > SMAX) || (s < SMIN);
      end
      4'd2: begin
        u = {32'd0, x} * {32'd0, y};
        e.res = u[31:0];
        e.lat = 33;
      end
      4'd3: begin
        e.lat = 34;
        if (y == 0) begin
          e.rem = x; e.dbz = 1'b1;
        end else begin
          e.res = x / y; e.rem = x % y;
        end
      end
      4'd5: begin
        e.lat = 34;
        if (y == 0) begin
          e.rem = x; e.dbz = 1'b1;
        end else begin
          q = sx / sy;
          r = sx % sy;
          e.res = q[31:0];
          e.rem = r[31:0];
          v = (q > SMAX);
        end
      end
      4'd4:  e.res = x & y;
      4'd6:  e.res = x | y;
      4'd7:  e.res = x ^ y;
      4'd8:  e.res = ~x;
      4'd9:  e.res = x << y[4:0];
      4'd10: e.res = x >> y[4:0];
      4'd11: e.res = $unsigned($signed(x) >>> y[4:0]);
      default: e.res = '0;
    endcase
    e.flg = {e.res[31], e.res == 32'd0, c, v};
    return e;
  endfunction

  // Called at a sample point; busy cycles get garbage on the inputs.
  task automatic send(input logic [3:0] o, input logic [31:0] x,
                      input logic [31:0] y, input int hold,
                      input bit push);
    exp_t e;
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      in_valid = 1'($urandom_range(0, 1));
      op = 4'($urandom);
      a  = $urandom;
      b  = $urandom;
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      in_valid = 1'b1;
      op = o; a = x; b = y;
      @(posedge clk); #1;
      in_valid = 1'b0;
      op = 4'($urandom);
      a  = $urandom;
      b  = $urandom;
      if (push) begin
        e = model(o, x, y);
        e.acc  = cyc;
        e.hold = hold;
        sbq.push_back(e);
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_queue", 64'(sbq.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    exp_t e;
    bit first;
    int hcnt;
    first = 1'b0;
    hcnt = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      if (!reset) begin
        first = 1'b0;
      end else if (out_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out_valid", 64'(out_valid), 64'd0);
          out_ready = 1'b1;
        end else begin
          e = sbq[0];
          if (!first) begin
            first = 1'b1;
            hcnt = 0;
            chk("latency", 64'(cyc - e.acc), 64'(e.lat));
          end
          chk("result", 64'(result), 64'(e.res));
          chk("remainder", 64'(remainder), 64'(e.rem));
          chk("flags", 64'(flags), 64'(e.flg));
          chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
          chk("in_ready_busy", 64'(in_ready), 64'd0);
          if (hcnt >= e.hold) begin
            out_ready = 1'b1;
            void'(sbq.pop_front());
            first = 1'b0;
          end else begin
            hcnt++;
          end
        end
      end
    end
  end

  initial begin : driver
    logic [31:0] pool [6];
    logic [3:0] o;
    logic [31:0] x, y;
    pool[0] = 32'h0;          pool[1] = 32'hFFFF_FFFF;
    pool[2] = 32'h8000_0000;  pool[3] = 32'h7FFF_FFFF;
    pool[4] = 32'h1;          pool[5] = 32'h2;
    reset = 1'b0;
    in_valid = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    send(4'd0, 32'h7FFF_FFFF, 32'h1, 0, 1'b1);
    send(4'd2, 32'h0001_0001, 32'h0001_0001, 10, 1'b1);
    send(4'd5, 32'hFFFF_FFF9, 32'h2, 0, 1'b1);
    send(4'd5, 32'h8000_0000, 32'hFFFF_FFFF, 2, 1'b1);
    send(4'd3, 32'h5, 32'h0, 0, 1'b1);
    send(4'd5, 32'h7, 32'hFFFF_FFFE, 1, 1'b1);
    send(4'd1, 32'h3, 32'h5, 0, 1'b1);
    send(4'd11, 32'h8000_00F0, 32'h24, 0, 1'b1);
    send(4'd9, 32'h1, 32'h1F, 0, 1'b1);
    send(4'd13, 32'h1234, 32'h5678, 0, 1'b1);
    drain();

    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom);
      x = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)]
                                      : $urandom;
      y = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)]
                                      : $urandom;
      send(o, x, y, int'($urandom_range(0, 3)), 1'b1);
    end
    drain();

    // Abandon a divide ten cycles in; nothing may come out.
    send(4'd3, 32'd1000, 32'd7, 0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_result", 64'(result), 64'd0);
    chk("mid_rst_remainder", 64'(remainder), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("post_abort_out_valid", 64'(out_valid), 64'd0);
    chk("post_abort_in_ready", 64'(in_ready), 64'd1);
    send(4'd0, 32'd2, 32'd3, 0, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
